mips_run_ctrl: RTL and testbench

Parametrised run controller for the pipelined MIPS core's simulation and board harness. After system reset it sequences the core's synchronous reset, then watches the core's retire stream. It counts cycles and retired instructions, detects the self-loop halt convention (the same PC retired repeatedly), and flags a watchdog timeout. A run can be restarted without a system reset.

---
 rtl/mips_run_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - run controller: core reset sequencing, retire counters, halt and watchdog detection
//
// Optional feature macro: RUN_CTRL_STALL_CNT_EN (enables stall_cnt; tied to 0 otherwise).
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low system reset
//   start      in   pulse: re-run the core from HALT or TMO
//   retire     in   core retired one instruction this cycle
//   retire_pc  in   PC of the retiring instruction
//   core_rst   out  active-high synchronous reset to the core (state HOLD)
//   running    out  state RUN
//   done       out  state HALT
//   timeout    out  state TMO
//   cycle_cnt  out  cycles spent in RUN
//   instr_cnt  out  retires accepted in RUN
//   stall_cnt  out  RUN cycles without a retire
module mips_run_ctrl #(
    parameter int RST_HOLD    = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 100000,
    parameter int HALT_REPEAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             retire,
    input  logic [31:0]      retire_pc,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int RW = $clog2(HALT_REPEAT + 1);

    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [RW-1:0]    REP_MAX   = RW'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic             TMO_EN    = (TIMEOUT != 0);

    typedef enum logic [3:0] {
        S_HOLD = 4'b0001,
        S_RUN  = 4'b0010,
        S_HALT = 4'b0100,
        S_TMO  = 4'b1000
    } state_t;

    state_t            state_q;
    logic [HW-1:0]     hold_q;
    logic [RW-1:0]     rep_q;
    logic [RW-1:0]     rep_d;
    logic [31:0]       last_pc_q;
    logic              pc_valid_q;
    logic [CNT_W-1:0]  cycle_q;
    logic [CNT_W-1:0]  instr_q;
    logic              core_rst_q;
    logic              running_q;
    logic              done_q;
    logic              timeout_q;
    logic              halt_hit;
    logic              tmo_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Repeat counter restarts at 1 on any new PC; a gap without retire keeps the run alive.
    always_comb begin
        rep_d = RW'(1);
        if (pc_valid_q && (retire_pc == last_pc_q)) begin
            rep_d = (rep_q == REP_MAX) ? rep_q : rep_q + RW'(1);
        end
        halt_hit = retire && (rep_d == REP_MAX);
        tmo_hit  = TMO_EN && (cycle_q == TMO_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_HOLD;
            hold_q     <= '0;
            rep_q      <= '0;
            last_pc_q  <= '0;
            pc_valid_q <= 1'b0;
            cycle_q    <= '0;
            instr_q    <= '0;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q    <= S_RUN;
                        hold_q     <= '0;
                        core_rst_q <= 1'b0;
                        running_q  <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                S_RUN: begin
                    cycle_q <= sat_inc(cycle_q);
                    if (retire) begin
                        instr_q    <= sat_inc(instr_q);
                        rep_q      <= rep_d;
                        last_pc_q  <= retire_pc;
                        pc_valid_q <= 1'b1;
                    end
                    // Halt takes priority over a coincident watchdog expiry.
                    if (halt_hit) begin
                        state_q   <= S_HALT;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q   <= S_TMO;
                        running_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                S_HALT, S_TMO: begin
                    if (start) begin
                        state_q    <= S_HOLD;
                        core_rst_q <= 1'b1;
                        done_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                        cycle_q    <= '0;
                        instr_q    <= '0;
                        rep_q      <= '0;
                        pc_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_HOLD;
                    hold_q     <= '0;
                    core_rst_q <= 1'b1;
                    running_q  <= 1'b0;
                    done_q     <= 1'b0;
                    timeout_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RUN_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if ((state_q == S_RUN) && !retire) begin
            stall_q <= sat_inc(stall_q);
        end else if (((state_q == S_HALT) || (state_q == S_TMO)) && start) begin
            stall_q <= '0;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign core_rst  = core_rst_q;
    assign running   = running_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb/tb_mips_run_ctrl.sv - self-checking bench for mips_run_ctrl with a behavioural reference model
module tb_mips_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        retire = 1'b0;
    logic [31:0] retire_pc = '0;

    // DUT A: RST_HOLD=4, CNT_W=8, TIMEOUT=10, HALT_REPEAT=3
    logic       core_rst_a, running_a, done_a, timeout_a;
    logic [7:0] cyc_a, ins_a, stl_a;
    // DUT B: RST_HOLD=1, CNT_W=4, watchdog disabled, HALT_REPEAT=2
    logic       core_rst_b, running_b, done_b, timeout_b;
    logic [3:0] cyc_b, ins_b, stl_b;

    int checks = 0;
    int failures = 0;

    mips_run_ctrl #(.RST_HOLD(4), .CNT_W(8), .TIMEOUT(10), .HALT_REPEAT(3)) dut_a (
        .clk(clk), .reset(reset), .start(start), .retire(retire), .retire_pc(retire_pc),
        .core_rst(core_rst_a), .running(running_a), .done(done_a), .timeout(timeout_a),
        .cycle_cnt(cyc_a), .instr_cnt(ins_a), .stall_cnt(stl_a)
    );

    mips_run_ctrl #(.RST_HOLD(1), .CNT_W(4), .TIMEOUT(0), .HALT_REPEAT(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .retire(retire), .retire_pc(retire_pc),
        .core_rst(core_rst_b), .running(running_b), .done(done_b), .timeout(timeout_b),
        .cycle_cnt(cyc_b), .instr_cnt(ins_b), .stall_cnt(stl_b)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0=HOLD 1=RUN 2=HALT 3=TMO; m_run is the length of the
    // current streak of identical retired PCs (0 = nothing retired since run start).
    int c_hold[2] = '{4, 1};
    int c_tmo[2]  = '{10, 0};
    int c_rep[2]  = '{3, 2};
    int c_max[2]  = '{255, 15};
    int m_phase[2], m_hold[2], m_cyc[2], m_ins[2], m_stl[2], m_run[2];
    logic [31:0] m_last[2];

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_hold[i] = 0; m_cyc[i] = 0; m_ins[i] = 0;
            m_stl[i] = 0; m_run[i] = 0; m_last[i] = '0;
        end
    endtask

    task automatic model_step(input int i);
        bit halt_now, tmo_now;
        case (m_phase[i])
            0: begin
                m_hold[i]++;
                if (m_hold[i] == c_hold[i]) begin
                    m_phase[i] = 1;
                    m_hold[i] = 0;
                end
            end
            1: begin
                halt_now = 0;
                tmo_now = (c_tmo[i] != 0) && (m_cyc[i] + 1 == c_tmo[i]);
                m_cyc[i] = sat(m_cyc[i] + 1, c_max[i]);
                if (retire) begin
                    m_ins[i] = sat(m_ins[i] + 1, c_max[i]);
                    if (m_run[i] > 0 && retire_pc == m_last[i]) m_run[i] = sat(m_run[i] + 1, c_rep[i]);
                    else m_run[i] = 1;
                    m_last[i] = retire_pc;
                    halt_now = (m_run[i] == c_rep[i]);
                end else begin
                    m_stl[i] = sat(m_stl[i] + 1, c_max[i]);
                end
                if (halt_now) m_phase[i] = 2;
                else if (tmo_now) m_phase[i] = 3;
            end
            default: begin
                if (start) begin
                    m_phase[i] = 0; m_cyc[i] = 0; m_ins[i] = 0; m_stl[i] = 0; m_run[i] = 0;
                end
            end
        endcase
    endtask

    // Drive inputs away from the edge, advance one edge, update the model, settle.
    task automatic tick(input bit s, input bit r, input logic [31:0] pc);
        start = s;
        retire = r;
        retire_pc = pc;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic reset_all();
        reset = 1'b0;
        model_reset();
        #2;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) tick(0, 0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (core_rst_a !== 1'b1) begin failures++; $display("FAIL reset_core_rst got=%b exp=1", core_rst_a); end
        checks++; if ({running_a, done_a, timeout_a} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {running_a, done_a, timeout_a}); end
        checks++; if ({cyc_a, ins_a, stl_a} !== 24'h0) begin failures++; $display("FAIL reset_counters got=%h exp=0", {cyc_a, ins_a, stl_a}); end
        checks++; if ({core_rst_b, running_b, cyc_b, ins_b} !== 10'b10_0000_0000) begin failures++; $display("FAIL reset_b got=%b", {core_rst_b, running_b, cyc_b, ins_b}); end
    endtask

    task automatic test_reset_release();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 32'h0);
            checks++; if (core_rst_a !== (k < 3)) begin failures++; $display("FAIL release_core_rst edge=%0d got=%b exp=%b", k + 1, core_rst_a, (k < 3)); end
            checks++; if (running_a !== (k == 3)) begin failures++; $display("FAIL release_running edge=%0d got=%b exp=%b", k + 1, running_a, (k == 3)); end
        end
        checks++; if (cyc_a !== 8'd0) begin failures++; $display("FAIL release_cycle got=%0d exp=0", cyc_a); end
        checks++; if (running_b !== 1'b1 || core_rst_b !== 1'b0) begin failures++; $display("FAIL release_b got=%b%b exp=10", running_b, core_rst_b); end
    endtask

    task automatic test_halt_detect();
        logic [31:0] pcs[5] = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008};
        for (int k = 0; k < 5; k++) begin
            tick(0, 1, pcs[k]);
            checks++; if (done_a !== (k == 4)) begin failures++; $display("FAIL halt_done retire=%0d got=%b exp=%b", k + 1, done_a, (k == 4)); end
        end
        checks++; if (ins_a !== 8'd5 || cyc_a !== 8'd5) begin failures++; $display("FAIL halt_counts got=%0d/%0d exp=5/5", ins_a, cyc_a); end
        checks++; if (running_a !== 1'b0 || timeout_a !== 1'b0) begin failures++; $display("FAIL halt_flags got=%b%b exp=00", running_a, timeout_a); end
        checks++; if (done_b !== 1'b1 || ins_b !== 4'd4) begin failures++; $display("FAIL halt_b got=%b/%0d exp=1/4", done_b, ins_b); end
        tick(0, 1, 32'h3008);
        checks++; if (ins_a !== 8'd5 || cyc_a !== 8'd5) begin failures++; $display("FAIL halt_freeze got=%0d/%0d exp=5/5", ins_a, cyc_a); end
    endtask

    task automatic test_restart();
        tick(1, 0, 32'h0);
        checks++; if (core_rst_a !== 1'b1 || done_a !== 1'b0) begin failures++; $display("FAIL restart_hold got=%b%b exp=10", core_rst_a, done_a); end
        checks++; if (cyc_a !== 8'd0 || ins_a !== 8'd0) begin failures++; $display("FAIL restart_clear got=%0d/%0d exp=0/0", cyc_a, ins_a); end
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 32'h0);
            checks++; if (core_rst_a !== (k < 3)) begin failures++; $display("FAIL restart_seq edge=%0d got=%b exp=%b", k + 1, core_rst_a, (k < 3)); end
        end
    endtask

    task automatic test_interrupted_loop();
        logic [31:0] pcs[5] = '{32'h3008, 32'h3008, 32'h300c, 32'h3008, 32'h3008};
        for (int k = 0; k < 5; k++) begin
            tick(0, 1, pcs[k]);
            checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL loop_no_halt retire=%0d got=%b exp=0", k + 1, done_a); end
        end
        tick(0, 1, 32'h3008);
        checks++; if (done_a !== 1'b1 || ins_a !== 8'd6) begin failures++; $display("FAIL loop_third got=%b/%0d exp=1/6", done_a, ins_a); end
    endtask

    task automatic test_timeout();
        logic [7:0] exp_stl;
`ifdef RUN_CTRL_STALL_CNT_EN
        exp_stl = 8'd10;
`else
        exp_stl = 8'd0;
`endif
        reset_all();
        for (int k = 0; k < 9; k++) tick(0, 0, 32'h0);
        checks++; if (timeout_a !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", timeout_a); end
        tick(0, 0, 32'h0);
        checks++; if (timeout_a !== 1'b1 || running_a !== 1'b0) begin failures++; $display("FAIL tmo_flag got=%b%b exp=10", timeout_a, running_a); end
        checks++; if (cyc_a !== 8'd10) begin failures++; $display("FAIL tmo_cycle got=%0d exp=10", cyc_a); end
        checks++; if (stl_a !== exp_stl) begin failures++; $display("FAIL tmo_stall got=%0d exp=%0d", stl_a, exp_stl); end
        tick(0, 1, 32'h1);
        tick(0, 0, 32'h0);
        checks++; if (cyc_a !== 8'd10 || ins_a !== 8'd0 || stl_a !== exp_stl) begin failures++; $display("FAIL tmo_freeze got=%0d/%0d/%0d", cyc_a, ins_a, stl_a); end
    endtask

    task automatic test_halt_tmo_same();
        reset_all();
        for (int k = 0; k < 7; k++) tick(0, 0, 32'h0);
        for (int k = 0; k < 3; k++) tick(0, 1, 32'h40);
        checks++; if (done_a !== 1'b1 || timeout_a !== 1'b0) begin failures++; $display("FAIL same_cycle got=done%b tmo%b exp=done1 tmo0", done_a, timeout_a); end
        checks++; if (cyc_a !== 8'd10 || ins_a !== 8'd3) begin failures++; $display("FAIL same_cycle_cnt got=%0d/%0d exp=10/3", cyc_a, ins_a); end
    endtask

    task automatic test_async_reset();
        reset_all();
        for (int k = 0; k < 3; k++) tick(0, 1, 32'h100 + 32'(4 * k));
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (core_rst_a !== 1'b1 || running_a !== 1'b0) begin failures++; $display("FAIL async_flags got=%b%b exp=10", core_rst_a, running_a); end
        checks++; if (cyc_a !== 8'd0 || ins_a !== 8'd0) begin failures++; $display("FAIL async_counters got=%0d/%0d exp=0/0", cyc_a, ins_a); end
        checks++; if (core_rst_b !== 1'b1 || cyc_b !== 4'd0) begin failures++; $display("FAIL async_b got=%b/%0d exp=1/0", core_rst_b, cyc_b); end
        #1;
    endtask

    task automatic test_saturation();
        reset_all();
        for (int k = 0; k < 20; k++) tick(0, 1, 32'h2000 + 32'(4 * k));
        checks++; if (cyc_b !== 4'hf || ins_b !== 4'hf) begin failures++; $display("FAIL sat_b got=%0d/%0d exp=15/15", cyc_b, ins_b); end
        checks++; if (running_b !== 1'b1 || timeout_b !== 1'b0) begin failures++; $display("FAIL sat_no_wdog got=%b%b exp=10", running_b, timeout_b); end
        checks++; if (timeout_a !== 1'b1 || cyc_a !== 8'd10 || ins_a !== 8'd10) begin failures++; $display("FAIL sat_a got=%b/%0d/%0d exp=1/10/10", timeout_a, cyc_a, ins_a); end
    endtask

    task automatic test_random();
        int o_core[2], o_run[2], o_done[2], o_tmo[2], o_cyc[2], o_ins[2], o_stl[2];
        int e_stl;
        reset_all();
        for (int n = 0; n < 400; n++) begin
            tick($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6, 32'h100 + 32'(4 * $urandom_range(0, 2)));
            o_core = '{int'(core_rst_a), int'(core_rst_b)};
            o_run  = '{int'(running_a), int'(running_b)};
            o_done = '{int'(done_a), int'(done_b)};
            o_tmo  = '{int'(timeout_a), int'(timeout_b)};
            o_cyc  = '{int'(cyc_a), int'(cyc_b)};
            o_ins  = '{int'(ins_a), int'(ins_b)};
            o_stl  = '{int'(stl_a), int'(stl_b)};
            for (int i = 0; i < 2; i++) begin
`ifdef RUN_CTRL_STALL_CNT_EN
                e_stl = m_stl[i];
`else
                e_stl = 0;
`endif
                checks++;
                if (o_core[i] != int'(m_phase[i] == 0) || o_run[i] != int'(m_phase[i] == 1) ||
                    o_done[i] != int'(m_phase[i] == 2) || o_tmo[i] != int'(m_phase[i] == 3)) begin
                    failures++;
                    $display("FAIL rand_state dut=%0d cyc=%0d got=%0d%0d%0d%0d exp_phase=%0d", i, n,
                             o_core[i], o_run[i], o_done[i], o_tmo[i], m_phase[i]);
                end
                checks++;
                if (o_cyc[i] != m_cyc[i] || o_ins[i] != m_ins[i] || o_stl[i] != e_stl) begin
                    failures++;
                    $display("FAIL rand_counts dut=%0d cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, n,
                             o_cyc[i], o_ins[i], o_stl[i], m_cyc[i], m_ins[i], e_stl);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_halt_detect();
        test_restart();
        test_interrupted_loop();
        test_timeout();
        test_halt_tmo_same();
        test_async_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
